ff_m_bist_ctrl: RTL and testbench

Single-clock March C- style built-in self-test initiator for the flop-array memories (ff_m_* family). Drives one write port and one read port of the array under test, using that array's read/write/address/data/byte-write port convention. Checks read data against expected patterns and reports pass/fail with the first failing address. Sits between the test/config logic and an array whose read and write clocks are both tied to this block's clock.

---
 rtl/ff_bist_pkg.sv | 38 +++
 rtl/ff_bist_cmp_pipe.sv | 74 +++++++
 rtl/ff_m_bist_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ff_m_bist_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_bist_pkg.sv
// Shared FSM states, March element codes and per-element access counts
// for the ff_m_* flop-array March C- self-test controller.
package ff_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_M0    = 3'd1,
    ST_M1    = 3'd2,
    ST_M2    = 3'd3,
    ST_M3    = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam logic [1:0] ELEM_M0 = 2'd0;
  localparam logic [1:0] ELEM_M1 = 2'd1;
  localparam logic [1:0] ELEM_M2 = 2'd2;
  localparam logic [1:0] ELEM_M3 = 2'd3;

  // Array accesses spent on each address, indexed by element code.
  localparam logic [1:0] OPS_PER_ADDR [4] = '{2'd1, 2'd2, 2'd2, 2'd1};

  function automatic logic [1:0] elemOf(input state_t s);
    logic [1:0] e;
    case (s)
      ST_M1:   e = ELEM_M1;
      ST_M2:   e = ELEM_M2;
      ST_M3:   e = ELEM_M3;
      default: e = ELEM_M0;
    endcase
    return e;
  endfunction

  function automatic logic isMarch(input state_t s);
    return (s == ST_M0) || (s == ST_M1) || (s == ST_M2) || (s == ST_M3);
  endfunction

endpackage

// File: rtl/ff_bist_cmp_pipe.sv
// Read-compare path: delays each read tag until its data returns from the
// array, flags miscompares and keeps the address/element of the first one.
module ff_bist_cmp_pipe #(
  parameter int WIDTH   = 4,
  parameter int BITADDR = 5,
  parameter int RDLAT   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_valid,
  input  logic [WIDTH-1:0]   i_exp,
  input  logic [BITADDR-1:0] i_adr,
  input  logic [1:0]         i_elem,
  input  logic [WIDTH-1:0]   i_dout,
  output logic               o_fail,
  output logic [BITADDR-1:0] o_failAdr,
  output logic [1:0]         o_failElem
);

  typedef struct packed {
    logic               valid;
    logic [WIDTH-1:0]   exp;
    logic [BITADDR-1:0] adr;
    logic [1:0]         elem;
  } tag_t;

  tag_t w_in;
  tag_t w_tap;
  logic w_miss;

  assign w_in = {i_valid, i_exp, i_adr, i_elem};

  generate
    if (RDLAT == 0) begin : g_direct
      assign w_tap = w_in;
    end else begin : g_delay
      tag_t r_dly [RDLAT];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < RDLAT; i++) r_dly[i] <= '0;
        end else begin
          r_dly[0] <= w_in;
          for (int i = 1; i < RDLAT; i++) r_dly[i] <= r_dly[i-1];
        end
      end

      assign w_tap = r_dly[RDLAT-1];
    end
  endgenerate

  assign w_miss = w_tap.valid && (i_dout != w_tap.exp);

  // fail is sticky; the location registers load only on the first miss.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_fail     <= 1'b0;
      o_failAdr  <= '0;
      o_failElem <= '0;
    end else if (i_clr) begin
      o_fail     <= 1'b0;
      o_failAdr  <= '0;
      o_failElem <= '0;
    end else if (w_miss) begin
      o_fail <= 1'b1;
      if (!o_fail) begin
        o_failAdr  <= w_tap.adr;
        o_failElem <= w_tap.elem;
      end
    end
  end

endmodule

// File: rtl/ff_m_bist_ctrl.sv
// March C- style BIST initiator for ff_m_* flop arrays: sequences the four
// March elements over 0..NUMADDR-1 and reports pass/fail with first failure.
module ff_m_bist_ctrl
  import ff_bist_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUMADDR = 32,
  parameter int BITADDR = 5,
  parameter int RDLAT   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               read,
  output logic               write,
  output logic [BITADDR-1:0] rd_adr,
  output logic [BITADDR-1:0] wr_adr,
  output logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   bw,
  input  logic [WIDTH-1:0]   rd_dout,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [BITADDR-1:0] fail_adr,
  output logic [1:0]         fail_elem
);

  localparam logic [BITADDR-1:0] LAST_ADR   = BITADDR'(NUMADDR - 1);
  localparam logic [1:0]         DRAIN_LAST = 2'(RDLAT - 1);

  state_t             r_state;
  logic [BITADDR-1:0] r_adr;
  logic               r_phase;
  logic [1:0]         r_drainCnt;
  logic               r_read;
  logic               r_write;
  logic [WIDTH-1:0]   r_din;
  logic [WIDTH-1:0]   r_bw;
  logic [WIDTH-1:0]   r_exp;
  logic [1:0]         r_elem;
  logic               r_busy;
  logic               r_done;

  state_t             w_nxtState;
  logic [BITADDR-1:0] w_nxtAdr;
  logic               w_nxtPhase;
  logic [1:0]         w_nxtDrain;
  logic               w_startAcc;
  logic               w_lastOp;
  logic               w_lastAdr;
  logic               w_nxtRead;
  logic               w_nxtWrite;
  logic [WIDTH-1:0]   w_nxtDin;
  logic [WIDTH-1:0]   w_nxtExp;

  assign w_lastOp  = ({1'b0, r_phase} == (OPS_PER_ADDR[elemOf(r_state)] - 2'd1));
  assign w_lastAdr = (r_state == ST_M2) ? (r_adr == '0) : (r_adr == LAST_ADR);

  // r_state/r_adr/r_phase name the access presented this cycle.
  always_comb begin
    w_nxtState = r_state;
    w_nxtAdr   = r_adr;
    w_nxtPhase = r_phase;
    w_nxtDrain = r_drainCnt;
    w_startAcc = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_startAcc = 1'b1;
          w_nxtState = ST_M0;
          w_nxtAdr   = '0;
          w_nxtPhase = 1'b0;
        end
      end
      ST_M0, ST_M1, ST_M2, ST_M3: begin
        if (!w_lastOp) begin
          w_nxtPhase = 1'b1;
        end else begin
          w_nxtPhase = 1'b0;
          if (w_lastAdr) begin
            case (r_state)
              ST_M0: begin
                w_nxtState = ST_M1;
                w_nxtAdr   = '0;
              end
              ST_M1: begin
                w_nxtState = ST_M2;
                w_nxtAdr   = LAST_ADR;
              end
              ST_M2: begin
                w_nxtState = ST_M3;
                w_nxtAdr   = '0;
              end
              default: begin
                w_nxtAdr = '0;
                if (RDLAT == 0) begin
                  w_nxtState = ST_DONE;
                end else begin
                  w_nxtState = ST_DRAIN;
                  w_nxtDrain = DRAIN_LAST;
                end
              end
            endcase
          end else if (r_state == ST_M2) begin
            w_nxtAdr = r_adr - BITADDR'(1);
          end else begin
            w_nxtAdr = r_adr + BITADDR'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (r_drainCnt == 2'd0) w_nxtState = ST_DONE;
        else                    w_nxtDrain = r_drainCnt - 2'd1;
      end
      default: w_nxtState = ST_IDLE;
    endcase
  end

  // Read-then-write elements read on phase 0 and write on phase 1.
  always_comb begin
    w_nxtRead  = 1'b0;
    w_nxtWrite = 1'b0;
    w_nxtDin   = '0;
    w_nxtExp   = '0;
    case (w_nxtState)
      ST_M0: w_nxtWrite = 1'b1;
      ST_M1: begin
        w_nxtRead  = !w_nxtPhase;
        w_nxtWrite = w_nxtPhase;
        w_nxtDin   = {WIDTH{w_nxtPhase}};
      end
      ST_M2: begin
        w_nxtRead  = !w_nxtPhase;
        w_nxtWrite = w_nxtPhase;
        w_nxtExp   = '1;
      end
      ST_M3: w_nxtRead = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_adr      <= '0;
      r_phase    <= 1'b0;
      r_drainCnt <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_din      <= '0;
      r_bw       <= '0;
      r_exp      <= '0;
      r_elem     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nxtState;
      r_adr      <= w_nxtAdr;
      r_phase    <= w_nxtPhase;
      r_drainCnt <= w_nxtDrain;
      r_read     <= w_nxtRead;
      r_write    <= w_nxtWrite;
      r_din      <= w_nxtDin;
      r_bw       <= {WIDTH{w_nxtWrite}};
      r_exp      <= w_nxtExp;
      r_elem     <= elemOf(w_nxtState);
      r_busy     <= isMarch(w_nxtState) || (w_nxtState == ST_DRAIN);
      r_done     <= (w_nxtState == ST_DONE);
    end
  end

  assign read   = r_read;
  assign write  = r_write;
  assign rd_adr = r_adr;
  assign wr_adr = r_adr;
  assign din    = r_din;
  assign bw     = r_bw;
  assign busy   = r_busy;
  assign done   = r_done;

  ff_bist_cmp_pipe #(
    .WIDTH   (WIDTH),
    .BITADDR (BITADDR),
    .RDLAT   (RDLAT)
  ) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_startAcc),
    .i_valid    (r_read),
    .i_exp      (r_exp),
    .i_adr      (r_adr),
    .i_elem     (r_elem),
    .i_dout     (rd_dout),
    .o_fail     (fail),
    .o_failAdr  (fail_adr),
    .o_failElem (fail_elem)
  );

endmodule

// File: tb/tb_ff_m_bist_ctrl.sv
// Scoreboard bench for ff_m_bist_ctrl: four instances (N/RDLAT variants) drive
// faulty flop-array models; a March reference model predicts accesses and results.
module tb_ff_m_bist_ctrl;

  localparam int NI = 4;

  typedef struct packed {
    logic       isWrite;
    logic [4:0] adr;
    logic [3:0] data;
    logic [3:0] bw;
  } op_t;

  typedef struct packed {
    logic       fail;
    logic [4:0] adr;
    logic [1:0] elem;
    logic [9:0] lat;
    logic       busy;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic start;

  logic       sRead [NI];
  logic       sWrite [NI];
  logic [4:0] sRdAdr [NI];
  logic [4:0] sWrAdr [NI];
  logic [3:0] sDin [NI];
  logic [3:0] sBw [NI];
  logic       sBusy [NI];
  logic       sDone [NI];
  logic       sFail [NI];
  logic [4:0] sFailAdr [NI];
  logic [1:0] sElem [NI];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int startCyc = 0;
  int faultKind = 0;
  int fAdr = 0;
  int fBit = 0;
  int fVal = 0;
  int aggAdr = 0;
  int vicAdr = 0;

  event startIssued;
  event flushAll;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Fault kinds: 1 = bit fAdr[fBit] stuck at fVal, 2 = writing 0 to aggAdr clears vicAdr.
  function automatic logic [3:0] faultyRead(input logic [3:0] stored, input int adr);
    logic [3:0] v;
    v = stored;
    if (faultKind == 1 && adr == fAdr) v[fBit] = fVal[0];
    return v;
  endfunction

  function automatic op_t mkOp(input logic w, input int a, input logic [3:0] d);
    op_t o;
    o.isWrite = w;
    o.adr     = a[4:0];
    o.data    = d;
    o.bw      = w ? 4'hF : 4'h0;
    return o;
  endfunction

  function automatic logic allDone();
    for (int i = 0; i < NI; i++) if (!sDone[i]) return 1'b0;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int N = (g < 2) ? 32 : 20;
    localparam int L = (g == 1) ? 2 : ((g == 3) ? 3 : 0);

    logic [3:0] mem [32];
    logic [3:0] rdPipe [4];
    logic [3:0] dout;
    op_t  opQ[$];
    res_t resQ[$];
    logic prevDone = 1'b0;

    ff_m_bist_ctrl #(
      .WIDTH   (4),
      .NUMADDR (N),
      .BITADDR (5),
      .RDLAT   (L)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .read      (sRead[g]),
      .write     (sWrite[g]),
      .rd_adr    (sRdAdr[g]),
      .wr_adr    (sWrAdr[g]),
      .din       (sDin[g]),
      .bw        (sBw[g]),
      .rd_dout   (dout),
      .busy      (sBusy[g]),
      .done      (sDone[g]),
      .fail      (sFail[g]),
      .fail_adr  (sFailAdr[g]),
      .fail_elem (sElem[g])
    );

    // Array under test: bit-write port plus an L-cycle read pipeline.
    always @(posedge clk) begin
      if (sWrite[g]) begin
        mem[sWrAdr[g]] <= (sDin[g] & sBw[g]) | (mem[sWrAdr[g]] & ~sBw[g]);
        if (faultKind == 2 && int'(sWrAdr[g]) == aggAdr && sDin[g] == 4'h0)
          mem[vicAdr] <= 4'h0;
      end
      rdPipe[0] <= faultyRead(mem[sRdAdr[g]], int'(sRdAdr[g]));
      for (int i = 1; i < 4; i++) rdPipe[i] <= rdPipe[i-1];
    end

    assign dout = (L == 0) ? faultyRead(mem[sRdAdr[g]], int'(sRdAdr[g]))
                           : rdPipe[(L == 0) ? 0 : L - 1];

    // Reference: walk the four March elements over an abstract memory.
    always @(startIssued) begin : model
      logic [3:0] m [32];
      logic [3:0] want;
      logic [3:0] val;
      logic       seen;
      int         a;
      res_t       r;
      for (int i = 0; i < 32; i++) m[i] = 4'h0;
      r    = '0;
      seen = 1'b0;
      for (int e = 0; e < 4; e++) begin
        for (int k = 0; k < N; k++) begin
          a = (e == 2) ? (N - 1 - k) : k;
          if (e != 0) begin
            want = (e == 2) ? 4'hF : 4'h0;
            opQ.push_back(mkOp(1'b0, a, 4'h0));
            if (!seen && faultyRead(m[a], a) != want) begin
              seen   = 1'b1;
              r.fail = 1'b1;
              r.adr  = a[4:0];
              r.elem = 2'(e);
            end
          end
          if (e != 3) begin
            val = (e == 1) ? 4'hF : 4'h0;
            opQ.push_back(mkOp(1'b1, a, val));
            m[a] = val;
            if (faultKind == 2 && a == aggAdr && val == 4'h0) m[vicAdr] = 4'h0;
          end
        end
      end
      r.lat  = 10'(6 * N + L + 1);
      r.busy = 1'b0;
      resQ.push_back(r);
    end

    always @(flushAll) begin
      opQ.delete();
      resQ.delete();
    end

    // Monitor: every array access and every rising done is checked.
    always @(negedge clk) begin : monitor
      op_t  obs;
      op_t  exp;
      res_t gotR;
      res_t expR;
      if (!rst) begin
        prevDone = 1'b0;
      end else begin
        if (sRead[g] || sWrite[g]) begin
          obs.isWrite = sWrite[g];
          obs.adr     = sWrite[g] ? sWrAdr[g] : sRdAdr[g];
          obs.data    = sWrite[g] ? sDin[g] : 4'h0;
          obs.bw      = sBw[g];
          vectors++;
          if (opQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_op inst %0d cyc %0d: got w=%0b adr=%0d, required no access",
                     g, cyc, obs.isWrite, obs.adr);
          end else begin
            exp = opQ.pop_front();
            if ((sRead[g] && sWrite[g]) || obs != exp) begin
              miscompares++;
              $display("[TB] FAIL op inst %0d cyc %0d: got rd=%0b wr=%0b adr=%0d data=%h bw=%h, required w=%0b adr=%0d data=%h bw=%h",
                       g, cyc, sRead[g], sWrite[g], obs.adr, obs.data, obs.bw,
                       exp.isWrite, exp.adr, exp.data, exp.bw);
            end
          end
        end
        if (sDone[g] && !prevDone) begin
          gotR.fail = sFail[g];
          gotR.adr  = sFailAdr[g];
          gotR.elem = sElem[g];
          gotR.lat  = 10'(cyc - startCyc + 1);
          gotR.busy = sBusy[g];
          vectors++;
          if (resQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_done inst %0d cyc %0d: got done=1, required 0", g, cyc);
          end else begin
            expR = resQ.pop_front();
            if (gotR != expR || opQ.size() != 0) begin
              miscompares++;
              $display("[TB] FAIL result inst %0d: got fail=%0b adr=%0d elem=%0d lat=%0d busy=%0b pending=%0d, required fail=%0b adr=%0d elem=%0d lat=%0d busy=0 pending=0",
                       g, gotR.fail, gotR.adr, gotR.elem, gotR.lat, gotR.busy, opQ.size(),
                       expR.fail, expR.adr, expR.elem, expR.lat);
            end
          end
        end
        prevDone = sDone[g];
      end
    end
  end

  task automatic checkOutput(input string name);
    logic [29:0] outs;
    for (int i = 0; i < NI; i++) begin
      outs = {sRead[i], sWrite[i], sRdAdr[i], sWrAdr[i], sDin[i], sBw[i],
              sBusy[i], sDone[i], sFail[i], sFailAdr[i], sElem[i]};
      vectors++;
      if (outs != 30'h0) begin
        miscompares++;
        $display("[TB] FAIL %s inst %0d: got outputs=%h, required 0", name, i, outs);
      end
    end
  endtask

  // kind 1: a=address b=bit v=value; kind 2: a=aggressor b=victim.
  task automatic applyStimulus(input int kind, input int a, input int b, input int v,
                               input int pulseAt, input int rstAt);
    int c;
    faultKind = kind;
    fAdr      = a;
    fBit      = b;
    fVal      = v;
    aggAdr    = a;
    vicAdr    = b;
    @(negedge clk);
    -> startIssued;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    startCyc = cyc;
    c = 1;
    while (!allDone() && c < 400) begin
      if (c == rstAt) begin
        #2 rst = 1'b0;
        -> flushAll;
        #1 checkOutput("reset_mid_test");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        return;
      end
      start = (c == pulseAt);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    vectors++;
    if (!allDone()) begin
      miscompares++;
      $display("[TB] FAIL done_timeout: got no done after %0d cycles, required done within 400", c);
    end
  endtask

  initial begin
    int k;
    int a;
    int b;
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state");
    rst = 1'b1;

    applyStimulus(0, 0, 0, 0, -1, -1);
    applyStimulus(1, 5, 2, 0, -1, -1);
    applyStimulus(2, 10, 9, 0, -1, -1);
    applyStimulus(1, 0, $urandom_range(0, 3), 1, -1, -1);
    applyStimulus(0, 0, 0, 0, 50, -1);
    applyStimulus(0, 0, 0, 0, -1, 3 * 32 + 1 + 2 * (32 - 1 - 7));
    applyStimulus(0, 0, 0, 0, -1, -1);

    for (int r = 0; r < 7; r++) begin
      k = $urandom_range(0, 2);
      a = $urandom_range(0, 19);
      if (k == 2) b = (a + 1 + $urandom_range(0, 18)) % 20;
      else        b = $urandom_range(0, 3);
      applyStimulus(k, a, b, $urandom_range(0, 1), -1, -1);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("[TB] FAIL watchdog: got no end of test by 500000, required earlier");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
